// File: rtl/machine_d_pkg.sv
// Shared constants for the machine_d up/down sequencer.
//   STATE_W  : width of the state vector
//   S_RESET  : state code forced while RESET is low
//   DIR_UP   : value of x that selects counting up
//   DIR_DOWN : value of x that selects counting down
package machine_d_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] S_RESET = 3'b000;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/d_ff.sv
// Single-bit D flip-flop with asynchronous active-low reset.
//   CLK   : clock, Q updates on the rising edge
//   RESET : asynchronous active-low reset, forces Q to RstVal
//   D     : data input
//   Q     : registered output
module d_ff #(
  parameter logic RstVal = 1'b0
) (
  input  logic CLK,
  input  logic RESET,
  input  logic D,
  output logic Q
);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Q <= RstVal;
    end else begin
      Q <= D;
    end
  end

endmodule

// File: rtl/machine_d.sv
// 3-bit Moore up/down sequencer built from three D flip-flops.
//   RESET : asynchronous active-low reset, S returns to 000 immediately
//   CLK   : clock, state advances on the rising edge
//   x     : direction, 0 counts up, 1 counts down (wraps in both directions)
//   S     : current state, taken straight from the flip-flop outputs
module machine_d
  import machine_d_pkg::*;
(
  input  logic               RESET,
  input  logic               CLK,
  input  logic               x,
  output logic [STATE_W-1:0] S
);

  logic [STATE_W-1:0] d;
  logic               down;

  assign down = (x == DIR_DOWN);

  // Bit 0 toggles every step; bit 1 toggles on a carry (up) or borrow (down) out of
  // bit 0; bit 2 toggles when the lower two bits are about to carry or borrow.
  assign d[0] = ~S[0];
  assign d[1] = S[1] ^ S[0] ^ x;
  assign d[2] = S[2] ^ (down ? (~S[1] & ~S[0]) : (S[1] & S[0]));

  for (genvar i = 0; i < STATE_W; i++) begin : g_bit
    d_ff #(
      .RstVal(S_RESET[i])
    ) u_ff (
      .CLK  (CLK),
      .RESET(RESET),
      .D    (d[i]),
      .Q    (S[i])
    );
  end

endmodule

// File: tb/tb_machine_d.sv
module tb_machine_d;

  logic       RESET;
  logic       CLK;
  logic       x;
  logic [2:0] S;

  int checks = 0;
  int errors = 0;

  machine_d dut (
    .RESET(RESET),
    .CLK  (CLK),
    .x    (x),
    .S    (S)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst_n;
    logic       dir;
    logic [2:0] exp;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: S=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    // Reset hold (clock edges ignored)
    vecs[0]  = '{1'b0, 1'b0, 3'd0};
    vecs[1]  = '{1'b0, 1'b0, 3'd0};
    // Release half a period before an edge, count up with 7->0 wrap
    vecs[2]  = '{1'b1, 1'b0, 3'd1};
    vecs[3]  = '{1'b1, 1'b0, 3'd2};
    vecs[4]  = '{1'b1, 1'b0, 3'd3};
    vecs[5]  = '{1'b1, 1'b0, 3'd4};
    vecs[6]  = '{1'b1, 1'b0, 3'd5};
    vecs[7]  = '{1'b1, 1'b0, 3'd6};
    vecs[8]  = '{1'b1, 1'b0, 3'd7};
    vecs[9]  = '{1'b1, 1'b0, 3'd0};
    vecs[10] = '{1'b1, 1'b0, 3'd1};
    vecs[11] = '{1'b1, 1'b0, 3'd2};
    // Count down from 2 with 0->7 wrap
    vecs[12] = '{1'b1, 1'b1, 3'd1};
    vecs[13] = '{1'b1, 1'b1, 3'd0};
    vecs[14] = '{1'b1, 1'b1, 3'd7};
    vecs[15] = '{1'b1, 1'b1, 3'd6};
    // Reach 5, then direction flips: up to 6, down to 5, up to 6
    vecs[16] = '{1'b1, 1'b1, 3'd5};
    vecs[17] = '{1'b1, 1'b0, 3'd6};
    vecs[18] = '{1'b1, 1'b1, 3'd5};
    vecs[19] = '{1'b1, 1'b0, 3'd6};

    RESET = 1'b1;
    x     = 1'b0;
    #1 RESET = 1'b0;
    #1 check("reset_async_initial", S, 3'd0);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge CLK);
      RESET = vecs[i].rst_n;
      x     = vecs[i].dir;
      @(posedge CLK);
      #1 check($sformatf("vec%0d", i), S, vecs[i].exp);
    end

    // Async reset between edges at S=6: clears before the next edge
    #2 RESET = 1'b0;
    #1 check("reset_midrun_async", S, 3'd0);
    @(posedge CLK);
    #1 check("reset_midrun_hold", S, 3'd0);
    @(negedge CLK);
    RESET = 1'b1;
    x     = 1'b1;
    @(posedge CLK);
    #1 check("release_down_first", S, 3'd7);
    @(posedge CLK);
    #1 check("release_down_second", S, 3'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
